// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 exception constants: ExcCodes, exception vector, flush FSM encoding.
// Pure declarations; no timing or flow control of its own.
package cp0_exc_ctrl_pkg;

  localparam logic [31:0] EXC_VEC_DEF = 32'hBFC0_0380;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } flush_state_e;

  typedef struct packed {
    logic adel_if;
    logic ri;
    logic ov;
    logic sys;
    logic bp;
    logic adel_ld;
    logic ades;
  } exf_t;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, TI latches on a match.
// All outputs registered, one-cycle update; no backpressure.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        cause_ti
);

  logic tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick     <= 1'b0;
      count    <= 32'd0;
      compare  <= 32'd0;
      cause_ti <= 1'b0;
    end else begin
      // A software write restarts the half-rate phase.
      if (count_we) begin
        count <= wdata;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick) count <= count + 32'd1;
      end

      if (compare_we) begin
        compare  <= wdata;
        cause_ti <= 1'b0;
      end else if (count == compare) begin
        cause_ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// WB-stage exception/ERET commit with prioritiser, redirect handshake FSM and CP0 timer.
// Commit outputs combinational in the WB cycle; flush_req held from the next cycle until flush_ack.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic [6:0]  ws_exf,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_eret,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [1:0]  cause_ip_sw,
  input  logic [5:0]  int_in,
  input  logic [31:0] cp0_epc,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] cp0_wdata,
  output logic        wb_ex,
  output logic [4:0]  wb_excode,
  output logic        wb_bd,
  output logic [31:0] wb_epc,
  output logic        badvaddr_we,
  output logic [31:0] wb_badvaddr,
  output logic        eret_flush,
  output logic        flush_req,
  output logic [31:0] flush_pc,
  input  logic        flush_ack,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        cause_ti
);

  exf_t         exf;
  logic [7:0]   ip_vec;
  logic         int_pend;
  logic         has_exc;
  logic         commit;
  logic [4:0]   pri_code;
  logic         pri_badv;
  logic [31:0]  pri_badv_val;
  flush_state_e state_q, state_d;
  logic [31:0]  flush_pc_q, flush_pc_d;

  assign exf      = exf_t'(ws_exf);
  // Timer interrupt shares IP7 with the top hardware line.
  assign ip_vec   = {cause_ti | int_in[5], int_in[4:0], cause_ip_sw};
  assign int_pend = (|(ip_vec & status_im)) & status_ie & ~status_exl;
  assign has_exc  = int_pend | (|ws_exf);
  assign commit   = (state_q == ST_IDLE) & ws_valid & ~reset;

  always_comb begin
    pri_code     = EXC_INT;
    pri_badv     = 1'b0;
    pri_badv_val = 32'd0;
    if (int_pend) begin
      pri_code = EXC_INT;
    end else if (exf.adel_if) begin
      pri_code     = EXC_ADEL;
      pri_badv     = 1'b1;
      pri_badv_val = ws_pc;
    end else if (exf.ri) begin
      pri_code = EXC_RI;
    end else if (exf.ov) begin
      pri_code = EXC_OV;
    end else if (exf.sys) begin
      pri_code = EXC_SYS;
    end else if (exf.bp) begin
      pri_code = EXC_BP;
    end else if (exf.adel_ld) begin
      pri_code     = EXC_ADEL;
      pri_badv     = 1'b1;
      pri_badv_val = ws_badvaddr;
    end else if (exf.ades) begin
      pri_code     = EXC_ADES;
      pri_badv     = 1'b1;
      pri_badv_val = ws_badvaddr;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_pc_d  = flush_pc_q;
    wb_ex       = 1'b0;
    wb_excode   = 5'd0;
    wb_bd       = 1'b0;
    wb_epc      = 32'd0;
    badvaddr_we = 1'b0;
    wb_badvaddr = 32'd0;
    eret_flush  = 1'b0;
    flush_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An exception always wins over a coincident ERET.
        if (commit && has_exc) begin
          wb_ex       = 1'b1;
          wb_excode   = pri_code;
          wb_bd       = ws_bd;
          wb_epc      = ws_bd ? ws_pc - 32'd4 : ws_pc;
          badvaddr_we = pri_badv;
          wb_badvaddr = pri_badv_val;
          state_d     = ST_REQ;
          flush_pc_d  = EXC_VEC;
        end else if (commit && ws_eret) begin
          eret_flush = 1'b1;
          state_d    = ST_REQ;
          flush_pc_d = cp0_epc;
        end
      end
      ST_REQ: begin
        flush_req = 1'b1;
        if (flush_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      flush_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign flush_pc = flush_pc_q;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .cause_ti   (cause_ti)
  );

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the exception/timer rules.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_bd;
  logic [6:0]  ws_exf;
  logic [31:0] ws_badvaddr;
  logic        ws_eret;
  logic        status_ie, status_exl;
  logic [7:0]  status_im;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  int_in;
  logic [31:0] cp0_epc;
  logic        count_we, compare_we;
  logic [31:0] cp0_wdata;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic        wb_bd;
  logic [31:0] wb_epc;
  logic        badvaddr_we;
  logic [31:0] wb_badvaddr;
  logic        eret_flush;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        flush_ack;
  logic [31:0] count, compare;
  logic        cause_ti;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.EXC_VEC(VEC)) dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_bd(ws_bd),
    .ws_exf(ws_exf), .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
    .cause_ip_sw(cause_ip_sw), .int_in(int_in), .cp0_epc(cp0_epc),
    .count_we(count_we), .compare_we(compare_we), .cp0_wdata(cp0_wdata),
    .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_epc(wb_epc),
    .badvaddr_we(badvaddr_we), .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush),
    .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack),
    .count(count), .compare(compare), .cause_ti(cause_ti)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: busy = redirect outstanding; count = base + cycles_since_load/2.
  bit          m_valid = 1'b0;
  bit          m_busy;
  logic [31:0] m_fpc, m_base, m_cmp;
  int unsigned m_elapsed;
  bit          m_ti;
  bit          x_ex, x_eret;

  // Exception codes by event index: 0=ades .. 6=adel_if, 7=interrupt (highest).
  logic [4:0]  code_tab [0:7] = '{5'h05, 5'h04, 5'h09, 5'h08, 5'h0C, 5'h0A, 5'h04, 5'h00};

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_elapsed / 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [7:0]  lines;
    logic [7:0]  ev;
    bit          ip, found, e_bvw;
    logic [4:0]  e_code;
    logic [31:0] e_bva;
    lines  = {m_ti | int_in[5], int_in[4:0], cause_ip_sw};
    ip     = ((lines & status_im) != 8'd0) && status_ie && !status_exl;
    ev     = {ip, ws_exf};
    found  = 1'b0;
    e_code = 5'd0;
    e_bvw  = 1'b0;
    e_bva  = 32'd0;
    for (int k = 7; k >= 0; k--) begin
      if (!found && ev[k]) begin
        found  = 1'b1;
        e_code = code_tab[k];
        e_bvw  = (k == 6) || (k == 1) || (k == 0);
        e_bva  = (k == 6) ? ws_pc : ws_badvaddr;
      end
    end
    x_ex   = !reset && !m_busy && ws_valid && found;
    x_eret = !reset && !m_busy && ws_valid && !found && ws_eret;
    if (m_valid) begin
      chk("wb_ex", wb_ex, x_ex);
      chk("eret_flush", eret_flush, x_eret);
      chk("badvaddr_we", badvaddr_we, x_ex && e_bvw);
      chk("flush_req", flush_req, m_busy);
      chk("flush_pc", flush_pc, m_fpc);
      chk("count", count, m_count());
      chk("compare", compare, m_cmp);
      chk("cause_ti", cause_ti, m_ti);
      if (x_ex) begin
        chk("wb_excode", wb_excode, e_code);
        chk("wb_bd", wb_bd, ws_bd);
        chk("wb_epc", wb_epc, ws_bd ? ws_pc - 32'd4 : ws_pc);
        if (e_bvw) chk("wb_badvaddr", wb_badvaddr, e_bva);
      end
    end
  endtask

  task automatic model_advance();
    logic [31:0] cnt;
    if (reset) begin
      m_valid = 1'b1; m_busy = 1'b0; m_fpc = 32'd0;
      m_base = 32'd0; m_elapsed = 0; m_cmp = 32'd0; m_ti = 1'b0;
    end else begin
      cnt = m_count();
      if (!m_busy && (x_ex || x_eret)) begin
        m_busy = 1'b1;
        m_fpc  = x_ex ? VEC : cp0_epc;
      end else if (m_busy && flush_ack) begin
        m_busy = 1'b0;
      end
      if (compare_we) m_ti = 1'b0;
      else if (cnt == m_cmp) m_ti = 1'b1;
      if (compare_we) m_cmp = cp0_wdata;
      if (count_we) begin m_base = cp0_wdata; m_elapsed = 0; end
      else m_elapsed++;
    end
  endtask

  task automatic settle();  @(negedge clk); model_check(); endtask
  task automatic advance(); model_advance(); @(posedge clk); #1; endtask
  task automatic cyc();     settle(); advance(); endtask

  task automatic quiet();
    reset = 0; ws_valid = 0; ws_exf = '0; ws_eret = 0; ws_bd = 0;
    flush_ack = 0; count_we = 0; compare_we = 0; int_in = '0;
    status_ie = 0; status_exl = 0; status_im = '0; cause_ip_sw = '0;
  endtask

  task automatic drain();
    ws_valid = 0; ws_exf = '0; ws_eret = 0; flush_ack = 1;
    cyc();
    flush_ack = 0;
  endtask

  bit seen;

  initial begin
    quiet();
    ws_pc = 32'd0; ws_badvaddr = 32'd0; cp0_epc = 32'd0; cp0_wdata = 32'd0;
    reset = 1;
    cyc(); cyc();
    reset = 0;

    settle();
    chk("rst_count", count, 32'd0);
    chk("rst_compare", compare, 32'd0);
    chk("rst_flush_req", flush_req, 1'b0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    chk("rst_ti", cause_ti, 1'b0);
    advance();

    // Overflow in a delay slot.
    ws_valid = 1; ws_exf = 7'b0010000; ws_bd = 1; ws_pc = 32'h1000;
    settle();
    chk("ov_ex", wb_ex, 1'b1);
    chk("ov_code", wb_excode, 5'h0C);
    chk("ov_epc", wb_epc, 32'h0FFC);
    chk("ov_bvw", badvaddr_we, 1'b0);
    advance();
    ws_valid = 0; ws_exf = '0; ws_bd = 0;
    settle();
    chk("ov_freq", flush_req, 1'b1);
    chk("ov_fpc", flush_pc, 32'hBFC0_0380);
    flush_ack = 1;
    advance();
    flush_ack = 0;
    settle();
    chk("ov_idle", flush_req, 1'b0);
    advance();

    // RI beats ADES; no BadVAddr write.
    ws_valid = 1; ws_exf = 7'b0100001; ws_badvaddr = 32'h0000_0FF3;
    settle();
    chk("ri_code", wb_excode, 5'h0A);
    chk("ri_bvw", badvaddr_we, 1'b0);
    advance();
    drain();

    // Load address error reports the data address.
    ws_valid = 1; ws_exf = 7'b0000010; ws_badvaddr = 32'hDEAD_0001;
    settle();
    chk("adel_code", wb_excode, 5'h04);
    chk("adel_bvw", badvaddr_we, 1'b1);
    chk("adel_bva", wb_badvaddr, 32'hDEAD_0001);
    advance();
    drain();

    // Fetch address error outranks OV and reports the PC.
    ws_valid = 1; ws_exf = 7'b1010000; ws_pc = 32'h0000_3003;
    settle();
    chk("adelif_code", wb_excode, 5'h04);
    chk("adelif_bva", wb_badvaddr, 32'h0000_3003);
    advance();
    drain();

    // ERET with delayed ack; WB traffic during REQ must be ignored.
    ws_valid = 1; ws_eret = 1; cp0_epc = 32'h2000;
    settle();
    chk("eret_flush", eret_flush, 1'b1);
    chk("eret_noex", wb_ex, 1'b0);
    advance();
    ws_eret = 0; ws_exf = 7'b0010000; cp0_epc = 32'h7777;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("eret_hold_req", flush_req, 1'b1);
      chk("eret_hold_pc", flush_pc, 32'h2000);
      chk("eret_hold_noex", wb_ex, 1'b0);
      advance();
    end
    ws_valid = 0; ws_exf = '0; flush_ack = 1;
    settle();
    chk("eret_ack_req", flush_req, 1'b1);
    advance();
    flush_ack = 0;
    settle();
    chk("eret_idle", flush_req, 1'b0);
    advance();

    // ERET together with SYSCALL is an exception.
    ws_valid = 1; ws_eret = 1; ws_exf = 7'b0001000;
    settle();
    chk("eretsys_ex", wb_ex, 1'b1);
    chk("eretsys_flush", eret_flush, 1'b0);
    chk("eretsys_code", wb_excode, 5'h08);
    advance();
    drain();

    // Reset while a redirect is outstanding.
    ws_valid = 1; ws_exf = 7'b0000100;
    cyc();
    ws_valid = 0; ws_exf = '0; reset = 1;
    settle();
    chk("rstreq_before", flush_req, 1'b1);
    advance();
    reset = 0;
    settle();
    chk("rstreq_after", flush_req, 1'b0);
    chk("rstreq_pc", flush_pc, 32'd0);
    advance();

    // Count wraps from all-ones two cycles after the write.
    count_we = 1; cp0_wdata = 32'hFFFF_FFFF;
    cyc();
    count_we = 0;
    settle(); chk("wrap_c0", count, 32'hFFFF_FFFF); advance();
    settle(); chk("wrap_c1", count, 32'hFFFF_FFFF); advance();
    settle(); chk("wrap_c2", count, 32'd0);         advance();

    // Timer interrupt through IM7.
    reset = 1; cyc(); reset = 0;
    compare_we = 1; cp0_wdata = 32'd5;
    cyc();
    compare_we = 0;
    status_im = 8'h80; status_ie = 1; status_exl = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      settle();
      if (cause_ti === 1'b1) begin
        seen = 1;
        chk("ti_count", count, 32'd5);
      end
      advance();
    end
    chk("ti_seen", {31'd0, seen}, 32'd1);
    ws_valid = 1; ws_pc = 32'h0000_4000;
    settle();
    chk("ti_int_ex", wb_ex, 1'b1);
    chk("ti_int_code", wb_excode, 5'h00);
    advance();
    quiet();
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      ws_valid    = 1'($urandom_range(0, 1));
      ws_pc       = $urandom;
      ws_bd       = 1'($urandom_range(0, 1));
      for (int b = 0; b < 7; b++) ws_exf[b] = ($urandom_range(0, 9) == 0);
      ws_badvaddr = $urandom;
      ws_eret     = ($urandom_range(0, 3) == 0);
      status_ie   = 1'($urandom_range(0, 1));
      status_exl  = 1'($urandom_range(0, 1));
      status_im   = 8'($urandom);
      cause_ip_sw = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      for (int b = 0; b < 6; b++) int_in[b] = ($urandom_range(0, 15) == 0);
      cp0_epc     = $urandom;
      flush_ack   = 1'($urandom_range(0, 1));
      count_we    = ($urandom_range(0, 49) == 0);
      compare_we  = ($urandom_range(0, 19) == 0);
      if (count_we)
        cp0_wdata = $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        cp0_wdata = m_count() + 32'($urandom_range(0, 12));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
